// File: rtl/proc_pkg.sv
// Shared opcode, program-word and sequencer-state definitions for the
// Processador front end; also imported by Controle and ALU.
package proc_pkg;

  localparam logic [7:0] OP_HALT   = 8'h13;
  localparam logic [7:0] OP_JUMP   = 8'h15;
  localparam logic [7:0] OP_RETURN = 8'h16;
  localparam logic [7:0] OP_NOP    = 8'hFF;

  localparam int unsigned WORD_W = 24;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src;
  } prog_word_t;

  localparam prog_word_t NOP_WORD = '{opcode: OP_NOP, dest: 8'h00, src: 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

  // Flow-control opcodes are resolved by the sequencer and never reach the core.
  function automatic logic is_flow_op(input logic [7:0] op);
    return (op == OP_JUMP) || (op == OP_RETURN);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-issue handshake between the sequencer (master) and the core (slave).
interface instr_sequencer_if;
  import proc_pkg::*;

  logic [7:0] instr;
  logic [7:0] instr_dest;
  logic [7:0] instr_src;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output instr,
    output instr_dest,
    output instr_src,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  instr,
    input  instr_dest,
    input  instr_src,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/ret_stack.sv
// LIFO return-address stack with a combinational top-of-stack read.
// Push when full and pop when empty are ignored; clear empties it in one cycle.
module ret_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == {SP_W{1'b0}});
  assign wr_idx_s = sp_q[IDX_W-1:0];
  assign rd_idx_s = wr_idx_s - IDX_W'(1);
  assign data_out = empty ? {WIDTH{1'b0}} : mem_q[rd_idx_s];

  // Next stack pointer and entry contents.
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = {SP_W{1'b0}};
    end else if (push && !full) begin
      mem_d[wr_idx_s] = data_in;
      sp_d            = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= {SP_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue front end: program memory, PC and call/return stack.
// Resolves JUMP/RETURN locally and hands datapath and HALT words to the core.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PROG_DEPTH = 2 ** ADDR_W,
  parameter int unsigned RET_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              start,
  instr_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  prog_word_t        last_q, last_d;
  prog_word_t        rdata_q;

  logic [WORD_W-1:0] prog_mem [PROG_DEPTH];

  logic              stk_push_s, stk_pop_s, stk_clear_s;
  logic              stk_full_s, stk_empty_s;
  logic [ADDR_W-1:0] stk_top_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              issue_s;

  assign pc_inc_s = pc_q + ADDR_W'(1);
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

  // While offering a word the core sees the fetched word; otherwise it sees
  // the last accepted word (NOP after reset), so flow opcodes never leak out.
  assign issue_s        = (state_q == ST_ISSUE) && !is_flow_op(rdata_q.opcode);
  assign bus.out_valid  = issue_s;
  assign bus.instr      = issue_s ? rdata_q.opcode : last_q.opcode;
  assign bus.instr_dest = issue_s ? rdata_q.dest   : last_q.dest;
  assign bus.instr_src  = issue_s ? rdata_q.src    : last_q.src;

  ret_stack #(
    .DEPTH (RET_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (stk_clear_s),
    .push     (stk_push_s),
    .pop      (stk_pop_s),
    .data_in  (pc_inc_s),
    .data_out (stk_top_s),
    .full     (stk_full_s),
    .empty    (stk_empty_s)
  );

  // Program image writes, allowed only while not executing.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      prog_mem[load_addr] <= load_data;
    end
  end

  // Sequencer next-state, PC, stack control and status flags.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    last_d      = last_q;
    stk_push_s  = 1'b0;
    stk_pop_s   = 1'b0;
    stk_clear_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED, ST_FAULT: begin
        if (start) begin
          state_d     = ST_FETCH;
          pc_d        = {ADDR_W{1'b0}};
          stk_clear_s = 1'b1;
          halted_d    = 1'b0;
          fault_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (rdata_q.opcode == OP_JUMP) begin
          if (stk_full_s) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            stk_push_s = 1'b1;
            pc_d       = rdata_q.src[ADDR_W-1:0];
            state_d    = ST_FETCH;
          end
        end else if (rdata_q.opcode == OP_RETURN) begin
          if (stk_empty_s) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            stk_pop_s = 1'b1;
            pc_d      = stk_top_s;
            state_d   = ST_FETCH;
          end
        end else if (bus.out_ready) begin
          last_d = rdata_q;
          if (rdata_q.opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            pc_d    = pc_inc_s;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; the read register doubles as the memory output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= {ADDR_W{1'b0}};
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      last_q   <= NOP_WORD;
      rdata_q  <= NOP_WORD;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      last_q   <= last_d;
      if (state_q == ST_FETCH) begin
        rdata_q <= prog_mem[pc_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected issued words go into a queue,
// and a negedge monitor compares every offered/accepted word against it.
module tb_instr_sequencer;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [23:0] load_data;
  logic        start;
  logic [7:0]  pc;
  logic        busy, halted, fault;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q [$];

  instr_sequencer_if bus_if ();

  instr_sequencer #(
    .ADDR_W     (8),
    .PROG_DEPTH (256),
    .RET_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .bus       (bus_if),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [23:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(halted || fault) && n < budget) begin
      tick();
      n++;
    end
    if (!(halted || fault)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no halt/fault within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus_if.out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus_if.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no out_valid within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard monitor: held words must match the queue head, accepted words pop it.
  always @(negedge clk) begin
    if (reset && bus_if.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h with no expected word",
                 {bus_if.instr, bus_if.instr_dest, bus_if.instr_src});
      end else if (bus_if.out_ready) begin
        chk("issue", {8'h00, bus_if.instr, bus_if.instr_dest, bus_if.instr_src},
            {8'h00, exp_q.pop_front()});
      end else begin
        chk("hold", {8'h00, bus_if.instr, bus_if.instr_dest, bus_if.instr_src},
            {8'h00, exp_q[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load_en = 1'b0; load_addr = 8'h00; load_data = 24'h000000;
    start = 1'b0;
    bus_if.out_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (2) tick();
    chk("rst_valid",  {31'h0, bus_if.out_valid}, 32'h0);
    chk("rst_instr",  {24'h0, bus_if.instr},     32'hFF);
    chk("rst_dest",   {24'h0, bus_if.instr_dest}, 32'h0);
    chk("rst_src",    {24'h0, bus_if.instr_src},  32'h0);
    chk("rst_pc",     {24'h0, pc},     32'h0);
    chk("rst_busy",   {31'h0, busy},   32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_fault",  {31'h0, fault},  32'h0);
    reset = 1'b1;
    tick();

    // Straight-line issue with out_ready held high.
    load_word(8'd0, 24'h000105);
    load_word(8'd1, 24'h010203);
    load_word(8'd2, 24'h130000);
    bus_if.out_ready = 1'b1;
    exp_q.push_back(24'h000105);
    exp_q.push_back(24'h010203);
    exp_q.push_back(24'h130000);
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("valid_cyc%0d", c), {31'h0, bus_if.out_valid}, {31'h0, (c % 2 == 0)});
      tick();
    end
    chk("t1_halted", {31'h0, halted}, 32'h1);
    chk("t1_pc",     {24'h0, pc},     32'h2);
    chk("t1_busy",   {31'h0, busy},   32'h0);
    chk("t1_frozen", {24'h0, bus_if.instr}, 32'h13);
    chk("t1_drain",  exp_q.size(), 32'h0);

    // Backpressure; a load attempted while busy must be ignored.
    bus_if.out_ready = 1'b0;
    exp_q.push_back(24'h000105);
    exp_q.push_back(24'h010203);
    exp_q.push_back(24'h130000);
    pulse_start();
    chk("t2_halt_clr", {31'h0, halted}, 32'h0);
    wait_valid("t2_valid", 10);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_pc_hold%0d", i), {24'h0, pc}, 32'h0);
      load_en   = (i == 2);
      load_addr = 8'd1;
      load_data = 24'h444444;
      tick();
      load_en   = 1'b0;
    end
    bus_if.out_ready = 1'b1;
    tick();
    chk("t2_pc_accept", {24'h0, pc}, 32'h1);
    wait_done("t2", 20);
    chk("t2_pc", {24'h0, pc}, 32'h2);

    // Call and return.
    load_word(8'd0,  24'h15000A);
    load_word(8'd10, 24'h000102);
    load_word(8'd11, 24'h160000);
    load_word(8'd1,  24'h130000);
    exp_q.push_back(24'h000102);
    exp_q.push_back(24'h130000);
    pulse_start();
    wait_done("t3", 40);
    chk("t3_halted", {31'h0, halted}, 32'h1);
    chk("t3_fault",  {31'h0, fault},  32'h0);
    chk("t3_pc",     {24'h0, pc},     32'h1);
    chk("t3_drain",  exp_q.size(), 32'h0);

    // Nine nested JUMPs overflow an 8-entry stack.
    for (int i = 0; i < 9; i++) begin
      load_word(8'(i), {8'h15, 8'h00, 8'(i + 1)});
    end
    pulse_start();
    wait_done("t4", 60);
    chk("t4_fault",  {31'h0, fault},  32'h1);
    chk("t4_halted", {31'h0, halted}, 32'h0);
    chk("t4_pc",     {24'h0, pc},     32'h8);
    repeat (3) tick();
    chk("t4_valid",  {31'h0, bus_if.out_valid}, 32'h0);
    chk("t4_pc_frz", {24'h0, pc}, 32'h8);
    chk("t4_busy",   {31'h0, busy}, 32'h0);

    // RETURN with an empty stack, then restart with load and start together.
    load_word(8'd0, 24'h160000);
    pulse_start();
    wait_done("t5a", 10);
    chk("t5_fault", {31'h0, fault}, 32'h1);
    chk("t5_pc",    {24'h0, pc},    32'h0);
    load_word(8'd1, 24'h130000);
    exp_q.push_back(24'h020709);
    exp_q.push_back(24'h130000);
    load_en = 1'b1; load_addr = 8'd0; load_data = 24'h020709;
    start = 1'b1;
    tick();
    load_en = 1'b0;
    start = 1'b0;
    chk("t5_fault_clr", {31'h0, fault}, 32'h0);
    wait_done("t5b", 20);
    chk("t5_halted", {31'h0, halted}, 32'h1);
    chk("t5_pc2",    {24'h0, pc},     32'h1);

    // Async reset while a word is being offered.
    load_word(8'd0, 24'h050607);
    bus_if.out_ready = 1'b0;
    exp_q.push_back(24'h050607);
    pulse_start();
    wait_valid("t6_valid", 10);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid",  {31'h0, bus_if.out_valid}, 32'h0);
    chk("t6_instr",  {24'h0, bus_if.instr},     32'hFF);
    chk("t6_pc",     {24'h0, pc},     32'h0);
    chk("t6_busy",   {31'h0, busy},   32'h0);
    chk("t6_halted", {31'h0, halted}, 32'h0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    load_word(8'd0, 24'h090807);
    bus_if.out_ready = 1'b1;
    exp_q.push_back(24'h090807);
    exp_q.push_back(24'h130000);
    pulse_start();
    wait_done("t6", 20);
    chk("t6_pc_end", {24'h0, pc}, 32'h1);
    chk("final_drain", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
